// File: rtl/unpacked_array_serializer_pkg.sv
// Shared types for the unpacked-array serializer: element count, index type, FSM states.
package unpacked_array_serializer_pkg;

  localparam int SER_N = 8;

  typedef logic [$clog2(SER_N)-1:0] ser_idx_t;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_SHIFT,
    SER_PAR
  } ser_state_t;

endpackage

// File: rtl/unpacked_array_serializer_if.sv
// Array interface I: writer modport P drives x, consumer modport C reads it.
interface I #(
  parameter int N = 8
);
  logic x [N-1:0];

  modport P (output x);
  modport C (input x);
endinterface

// File: rtl/unpacked_array_serializer.sv
// Snapshots I.x on i_start and streams it out one bit per valid/ready beat.
// Define UNPACKED_ARRAY_SERIALIZER_PARITY_EN to append an even-parity beat.
module unpacked_array_serializer
  import unpacked_array_serializer_pkg::*;
#(
  parameter int N         = SER_N,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  I.C          c,
  input  logic i_start,
  input  logic i_ready,
  output logic o_valid,
  output logic o_data,
  output logic o_last,
  output logic o_busy,
  output logic o_done
);

  localparam int            IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  // Handshake: a beat moves on a rising edge where o_valid && i_ready; while
  // stalled, o_data/o_last/idx hold and o_valid stays high until the frame ends.
  ser_state_t    r_state;
  ser_state_t    w_state_nxt;
  logic          r_snap [N-1:0];
  logic [IW-1:0] r_idx;
  logic          r_done;
  logic          w_capture;
  logic          w_final;
  logic [IW-1:0] w_pos;
  logic          w_elem;

  assign w_pos  = LSB_FIRST ? r_idx : (LAST_IDX - r_idx);
  assign w_elem = r_snap[w_pos];

`ifdef UNPACKED_ARRAY_SERIALIZER_PARITY_EN
  logic w_parity;

  always_comb begin
    w_parity = 1'b0;
    foreach (r_snap[i]) w_parity = w_parity ^ r_snap[i];
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_final     = 1'b0;
    o_valid     = 1'b0;
    o_data      = 1'b0;
    o_last      = 1'b0;
    case (r_state)
      SER_SHIFT: begin
        o_valid = 1'b1;
        o_data  = w_elem;
`ifdef UNPACKED_ARRAY_SERIALIZER_PARITY_EN
        if (i_ready && (r_idx == LAST_IDX)) w_state_nxt = SER_PAR;
`else
        o_last = (r_idx == LAST_IDX);
        if (i_ready && (r_idx == LAST_IDX)) begin
          w_state_nxt = SER_IDLE;
          w_final     = 1'b1;
        end
`endif
      end
`ifdef UNPACKED_ARRAY_SERIALIZER_PARITY_EN
      SER_PAR: begin
        o_valid = 1'b1;
        o_last  = 1'b1;
        o_data  = w_parity;
        if (i_ready) begin
          w_state_nxt = SER_IDLE;
          w_final     = 1'b1;
        end
      end
`endif
      default: begin
        if (i_start) begin
          w_state_nxt = SER_SHIFT;
          w_capture   = 1'b1;
        end
      end
    endcase
  end

  // idx saturates at the last element so it never wraps inside a frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= SER_IDLE;
      r_idx   <= '0;
      r_done  <= 1'b0;
      foreach (r_snap[i]) r_snap[i] <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_final;
      if (w_capture) begin
        foreach (r_snap[i]) r_snap[i] <= c.x[i];
        r_idx <= '0;
      end else if ((r_state == SER_SHIFT) && i_ready && (r_idx != LAST_IDX)) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign o_busy = (r_state != SER_IDLE);
  assign o_done = r_done;

endmodule

// File: tb/tb_unpacked_array_serializer.sv
// Bench: two serializers (LSB-first and MSB-first) share stimulus and are checked
// every cycle against a frame-level model; directed frames pin the model with literals.
module tb_unpacked_array_serializer;

  localparam int N = 8;
`ifdef UNPACKED_ARRAY_SERIALIZER_PARITY_EN
  localparam int BEATS       = N + 1;
  localparam bit EXP_LAST_07 = 1'b1;
`else
  localparam int BEATS       = N;
  localparam bit EXP_LAST_07 = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic ready;
  logic a_valid, a_data, a_last, a_busy, a_done;
  logic b_valid, b_data, b_last, b_busy, b_done;

  I #(.N(N)) if_a ();
  I #(.N(N)) if_b ();

  unpacked_array_serializer #(.N(N), .LSB_FIRST(1'b1)) u_a (
    .i_clk(clk), .i_rst(rst), .c(if_a), .i_start(start), .i_ready(ready),
    .o_valid(a_valid), .o_data(a_data), .o_last(a_last), .o_busy(a_busy), .o_done(a_done)
  );

  unpacked_array_serializer #(.N(N), .LSB_FIRST(1'b0)) u_b (
    .i_clk(clk), .i_rst(rst), .c(if_b), .i_start(start), .i_ready(ready),
    .o_valid(b_valid), .o_data(b_data), .o_last(b_last), .o_busy(b_busy), .o_done(b_done)
  );

  always #5 clk = ~clk;

  // ---------------- model and bookkeeping ----------------
  int         n_chk = 0;
  int         n_err = 0;
  bit         chk_en = 1'b0;
  logic [7:0] cur_x;
  bit         m_busy;
  int         m_k;
  logic [7:0] m_snap;
  bit         m_done;
  bit         hist_a [512];
  bit         hist_b [512];
  int         n_acc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Beat k of a frame: element k (or N-1-k) of the snapshot, then even parity.
  function automatic bit exp_data(input bit lsb);
    if (!m_busy) return 1'b0;
    if (m_k < N) return lsb ? m_snap[m_k] : m_snap[N-1-m_k];
    return ^m_snap;
  endfunction

  function automatic bit exp_last();
    return m_busy && (m_k == BEATS - 1);
  endfunction

  task automatic model_update();
    bit nd;
    if (rst) begin
      m_busy = 1'b0;
      m_k    = 0;
      m_snap = '0;
      m_done = 1'b0;
    end else begin
      nd = 1'b0;
      if (m_busy) begin
        if (ready) begin
          if (n_acc < 512) begin
            hist_a[n_acc] = exp_data(1'b1);
            hist_b[n_acc] = exp_data(1'b0);
          end
          n_acc++;
          m_k++;
          if (m_k == BEATS) begin
            m_busy = 1'b0;
            nd     = 1'b1;
          end
        end
      end else if (start) begin
        m_snap = cur_x;
        m_k    = 0;
        m_busy = 1'b1;
      end
      m_done = nd;
    end
  endtask

  task automatic compare();
    chk("a_valid", a_valid, m_busy);
    chk("a_data",  a_data,  exp_data(1'b1));
    chk("a_last",  a_last,  exp_last());
    chk("a_busy",  a_busy,  m_busy);
    chk("a_done",  a_done,  m_done);
    chk("b_valid", b_valid, m_busy);
    chk("b_data",  b_data,  exp_data(1'b0));
    chk("b_last",  b_last,  exp_last());
    chk("b_busy",  b_busy,  m_busy);
    chk("b_done",  b_done,  m_done);
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic step();
    @(negedge clk);
    if (chk_en) compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_x(input logic [7:0] v);
    cur_x = v;
    for (int i = 0; i < N; i++) begin
      if_a.x[i] = v[i];
      if_b.x[i] = v[i];
    end
  endtask

  function automatic logic [7:0] seq_a(input int base);
    logic [7:0] s;
    for (int i = 0; i < 8; i++) s[i] = hist_a[base + i];
    return s;
  endfunction

  function automatic logic [7:0] seq_b(input int base);
    logic [7:0] s;
    for (int i = 0; i < 8; i++) s[i] = hist_b[base + i];
    return s;
  endfunction

  // rmode 0: always ready, 1: pattern 1,0,0,1..., 2: random.
  // disturb: overwrite x with all-ones after capture and re-pulse start mid-frame.
  task automatic run_frame(input logic [7:0] v, input int rmode, input bit disturb,
                           output int base, output int cyc);
    set_x(v);
    ready = 1'b1;
    start = 1'b1;
    base  = n_acc;
    step();
    start = 1'b0;
    if (disturb) set_x(8'hFF);
    cyc = 1;
    while (!a_done && cyc < 60) begin
      case (rmode)
        0:       ready = 1'b1;
        1:       ready = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
        default: ready = ($urandom_range(0, 2) != 0);
      endcase
      start = disturb && (cyc == 3);
      step();
      cyc++;
    end
    start = 1'b0;
    chk("frame_done_seen", a_done, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int cyc;
    int p;
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    set_x(8'h00);
    m_busy = 1'b0;
    m_k    = 0;
    m_snap = '0;
    m_done = 1'b0;
    repeat (3) step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_valid", a_valid, 0);
    chk("rst_busy",  b_busy,  0);
    chk("rst_done",  a_done,  0);

    // Directed 1: full-rate frame, done in cycle t+BEATS+1.
    run_frame(8'hB2, 0, 1'b0, base, cyc);
    chk("d1_done_cycle", cyc, BEATS + 1);
    chk("d1_seq_lsb", seq_a(base), 8'hB2);
    chk("d1_seq_msb", seq_b(base), 8'h4D);
    chk("d1_beats", n_acc - base, BEATS);

    // Directed 2: stalls 1,0,0,1 repeating.
    step();
    run_frame(8'hB2, 1, 1'b0, base, cyc);
    chk("d2_seq_lsb", seq_a(base), 8'hB2);
    chk("d2_beats", n_acc - base, BEATS);

    // Directed 3: x changes and start re-pulsed after capture.
    step();
    run_frame(8'hB2, 2, 1'b1, base, cyc);
    chk("d3_seq_lsb", seq_a(base), 8'hB2);
    chk("d3_seq_msb", seq_b(base), 8'h4D);
    chk("d3_beats", n_acc - base, BEATS);

    // Directed 4: reset after three beats, then a clean frame.
    step();
    set_x(8'hB2);
    ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("d4_rst_valid", a_valid, 0);
    chk("d4_rst_busy", a_busy, 0);
    chk("d4_rst_done", a_done, 0);
    step();
    chk("d4_no_done", a_done, 0);
    run_frame(8'h01, 0, 1'b0, base, cyc);
    chk("d4_seq_lsb", seq_a(base), 8'h01);
    chk("d4_seq_msb", seq_b(base), 8'h80);

    // Directed 5: three ones; last beat is parity 1 when enabled.
    step();
    run_frame(8'h07, 0, 1'b0, base, cyc);
    chk("d5_beats", n_acc - base, BEATS);
    chk("d5_last_beat", hist_a[base + BEATS - 1], EXP_LAST_07);

    // Random frames with backpressure, spurious starts, x churn and resets.
    for (int f = 0; f < 120; f++) begin
      repeat ($urandom_range(0, 2)) begin
        start = ($urandom_range(0, 3) == 0);
        ready = $urandom_range(0, 1);
        set_x(8'($urandom));
        step();
      end
      set_x(8'($urandom));
      start = 1'b1;
      step();
      p = 0;
      while (a_busy && p < 200) begin
        ready = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 5) == 0) set_x(8'($urandom));
        if ($urandom_range(0, 60) == 0) begin
          rst = 1'b1;
          step();
          rst = 1'b0;
          break;
        end
        step();
        p++;
      end
      chk("rand_frame_bound", (p < 200) ? 1 : 0, 1);
    end
    start = 1'b0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
